// File: rtl/memstream_afull_fifo.sv
// rtl/memstream_afull_fifo.sv - per-stream FWFT output buffer with almost-full throttle for a memstream port
//
// Ports:
//   aclk, aresetn        clock (rising edge) and asynchronous active-low reset
//   s_axis_tvalid/tdata  valid-only write side from the memstream (no tready)
//   s_axis_afull         almost-full, combinational decode of the registered count
//   m_axis_tvalid/tready/tdata  AXI-Stream master side, tdata driven from a register
//   count                occupancy 0..DEPTH including the output register
//   overflow             sticky flag, set when a write is dropped
module memstream_afull_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int AFULL_MARGIN = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_tvalid,
    input  logic [WIDTH-1:0]         s_axis_tdata,
    output logic                     s_axis_afull,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [WIDTH-1:0]         m_axis_tdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_TH = CW'(DEPTH - AFULL_MARGIN);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 2);

    // The RAM holds DEPTH-1 entries; the output register is the last slot.
    logic [WIDTH-1:0] mem [DEPTH-1];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    ram_cnt;
    logic             ram_empty;
    logic             pop;
    logic             accept;
    logic             to_out;
    logic             to_ram;
    logic             reload;
    logic [WIDTH-1:0] ram_head;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // The output register is always filled before the RAM, so RAM
    // occupancy is the total minus the output register's valid bit.
    assign ram_cnt   = count - CW'(m_axis_tvalid);
    assign ram_empty = (ram_cnt == '0);
    assign ram_head  = mem[rd_ptr];

    assign pop    = m_axis_tvalid & m_axis_tready;
    assign accept = s_axis_tvalid & ((count < DEPTH_C) | pop);
    // Bypass into the output register when it is (or is about to be) empty
    // and nothing older waits in the RAM.
    assign to_out = accept & (~m_axis_tvalid | (pop & ram_empty));
    assign to_ram = accept & ~to_out;
    assign reload = pop & ~ram_empty;

    assign s_axis_afull = (count >= AFULL_TH);

    // No reset on the storage array. When RAM is full and a push and pop
    // coincide, wr_ptr == rd_ptr; the asynchronous read returns the old
    // head before this write lands.
    always_ff @(posedge aclk) begin
        if (to_ram) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            count         <= '0;
            overflow      <= 1'b0;
        end else begin
            if (to_ram) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (reload) begin
                rd_ptr <= ptr_next(rd_ptr);
            end

            if (to_out) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
            end else if (reload) begin
                m_axis_tdata  <= ram_head;
            end else if (pop) begin
                m_axis_tvalid <= 1'b0;
            end

            if (accept && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !accept) begin
                count <= count - CW'(1);
            end

            if (s_axis_tvalid && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memstream_afull_fifo.sv
// tb/tb_memstream_afull_fifo.sv - self-checking bench for memstream_afull_fifo
module tb_memstream_afull_fifo;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int MARGIN = 8;
    localparam int NSTREAM = 200;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic [WIDTH-1:0]  s_axis_tdata = '0;
    logic              s_axis_afull;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [WIDTH-1:0]  m_axis_tdata;
    logic [$clog2(DEPTH):0] count;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of beats plus a sticky drop flag.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf = 0;
    logic [WIDTH-1:0] rx[$];
    int               peak = 0;

    memstream_afull_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_afull  (s_axis_afull),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .count         (count),
        .overflow      (overflow)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'(q.size() > 0));
        chk({tag, "_count"}, 64'(count), 64'(q.size()));
        chk({tag, "_afull"}, 64'(s_axis_afull), 64'(q.size() >= DEPTH - MARGIN));
        chk({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
        if (q.size() > 0) chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'(q[0]));
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge from the pre-edge state, then compare 1 time unit later.
    task automatic cyc(input string tag, input bit wr, input logic [WIDTH-1:0] d, input bit rdy);
        bit p;
        bit acc;
        @(negedge aclk);
        s_axis_tvalid = wr;
        s_axis_tdata  = d;
        m_axis_tready = rdy;
        #1;
        if (m_axis_tvalid && rdy) rx.push_back(m_axis_tdata);
        @(posedge aclk);
        p   = (q.size() > 0) && rdy;
        acc = wr && ((q.size() < DEPTH) || p);
        if (p) void'(q.pop_front());
        if (acc) q.push_back(d);
        if (wr && !acc) m_ovf = 1;
        if (q.size() > peak) peak = q.size();
        #1;
        chk_state(tag);
    endtask

    initial begin
        int sent;
        int cycles;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk_state("reset");
        chk("reset_tdata", 64'(m_axis_tdata), 64'd0);

        // Single beat
        cyc("single_wr", 1, 32'hA5A5A5A5, 0);
        chk("single_data", 64'(m_axis_tdata), 64'hA5A5A5A5);
        chk("single_count", 64'(count), 64'd1);
        cyc("single_hold", 0, 32'h0, 0);
        cyc("single_pop", 0, 32'h0, 1);
        chk("single_empty", 64'(m_axis_tvalid), 64'd0);

        // Fill to afull, then to full
        for (int i = 0; i < 24; i++) begin
            cyc("fill", 1, $urandom, 0);
            if (i == 22) chk("afull_at_23", 64'(s_axis_afull), 64'd0);
        end
        chk("afull_at_24", 64'(s_axis_afull), 64'd1);
        chk("count_24", 64'(count), 64'd24);
        for (int i = 0; i < 8; i++) cyc("fill_full", 1, $urandom, 0);
        chk("count_full", 64'(count), 64'd32);
        chk("ovf_clear_full", 64'(overflow), 64'd0);

        // Overflow: dropped write, then write with simultaneous pop
        cyc("drop", 1, 32'hDEAD0001, 0);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("count_after_drop", 64'(count), 64'd32);
        cyc("push_pop_full", 1, 32'hBEEF0002, 1);
        chk("count_push_pop_full", 64'(count), 64'd32);
        cyc("ovf_sticky", 0, 32'h0, 0);
        chk("ovf_still", 64'(overflow), 64'd1);

        // Drain with random tready
        cycles = 0;
        while (q.size() > 0 && cycles < 500) begin
            cyc("drain", 0, 32'h0, 1'($urandom_range(0, 1)));
            cycles++;
        end
        chk("drain_done", 64'(q.size()), 64'd0);

        // Streaming with wrap: writer honours afull as the memstream would
        rx.delete();
        peak = 0;
        sent = 0;
        cycles = 0;
        while ((sent < NSTREAM || q.size() > 0) && cycles < 3000) begin
            bit w;
            w = (sent < NSTREAM) && !(q.size() >= DEPTH - MARGIN);
            cyc("stream", w, 32'(sent), 1'($urandom_range(0, 1)));
            if (w) sent++;
            cycles++;
        end
        chk("stream_rx_count", 64'(rx.size()), 64'(NSTREAM));
        for (int i = 0; i < rx.size() && i < NSTREAM; i++)
            chk("stream_order", 64'(rx[i]), 64'(i));
        chk("stream_peak_lt_depth", 64'(peak < DEPTH), 64'd1);

        // Async reset mid-stream at count=10
        for (int i = 0; i < 10; i++) cyc("pre_reset", 1, 32'h100 + 32'(i), 0);
        chk("pre_reset_count", 64'(count), 64'd10);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        q.delete();
        m_ovf = 0;
        chk_state("async_reset");
        chk("async_reset_tdata", 64'(m_axis_tdata), 64'd0);
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        cyc("post_reset_wr", 1, 32'h5EED5EED, 0);
        chk("post_reset_count", 64'(count), 64'd1);
        cyc("post_reset_pop", 0, 32'h0, 1);
        chk("post_reset_empty", 64'(m_axis_tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
